// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified RAM port arbiter:
//   - arb_state_e : arbiter FSM state encodings (2-bit)
//   - arb_id_e    : requester identifiers (fetch = 0, data = 1)
// No ports (package).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_ACK     = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_ID_IF = 1'b0,
        ARB_ID_D  = 1'b1
    } arb_id_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles spent waiting for the RAM to answer. The arbiter clears it on
// every grant and enables it in each busy cycle without mem_ready.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset (count -> 0)
//   clr_i      in   clear count to 0 (has priority over en_i)
//   en_i       in   increment count
//   expired_o  out  count == TIMEOUT
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one RAM port between the instruction-fetch requester and the data
// requester. Each level request becomes one RAM req/ready transaction; the
// requester gets a one-cycle ack (with err if the watchdog aborted it).
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters are pending; otherwise data always beats fetch.
// Ports:
//   clk, reset                           clock / async active-high reset
//   if_req, if_addr                      fetch request (level) and address
//   if_ack, if_rdata                     fetch completion pulse, fetched word
//   d_req, d_we, d_addr, d_wdata         data request, store flag, addr, data
//   d_ack, d_rdata                       data completion pulse, load data
//   err                                  with an ack: transaction timed out
//   mem_req, mem_we, mem_addr, mem_wdata RAM request side (held until ready)
//   mem_rdata, mem_ready                 RAM response side
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    arb_id_e           winner;
    logic              wd_clr, wd_en, wd_expired;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_id_e           last_grant_q, last_grant_d;
`endif

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        winner      = ARB_ID_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (if_req || d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    // Contention goes to whoever did not win last time.
                    if (if_req && d_req) begin
                        winner = (last_grant_q == ARB_ID_D) ? ARB_ID_IF : ARB_ID_D;
                    end else begin
                        winner = d_req ? ARB_ID_D : ARB_ID_IF;
                    end
                    last_grant_d = winner;
`else
                    winner = d_req ? ARB_ID_D : ARB_ID_IF;
`endif
                    mem_req_d = 1'b1;
                    wd_clr    = 1'b1;
                    if (winner == ARB_ID_D) begin
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        state_d     = ARB_BUSY_D;
                    end else begin
                        mem_addr_d = if_addr;
                        mem_we_d   = 1'b0;
                        state_d    = ARB_BUSY_IF;
                    end
                end
            end
            ARB_BUSY_IF, ARB_BUSY_D: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_ACK;
                    if (state_q == ARB_BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (wd_expired) begin
                    // Abort: complete the handshake towards the requester
                    // with err set, leaving its read data untouched.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ARB_ACK;
                    if (state_q == ARB_BUSY_IF) begin
                        if_ack_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                    end
                end else begin
                    wd_en = 1'b1;
                end
            end
            // Guard cycle: a request still high while its ack is visible
            // must not be granted a second time.
            ARB_ACK: state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= ARB_ID_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench: directed scenarios followed by randomized trials. The
// bench plays the RAM (per-transaction latency) and predicts grant order,
// busy length, ack/err and read-data registers at transaction level.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_ack, d_ack, err;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: read-data registers and who was granted last (0 = IF, 1 = D).
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata  = '0;
    bit            m_last     = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One trial: raise the selected requests at the current negedge, act as the
    // RAM, and check every transaction against the predicted outcome.
    task automatic run_trial(input bit w_if, input bit w_d,
                             input logic [31:0] ia, input logic [31:0] da,
                             input logic [31:0] dwd, input bit dwe,
                             input int lat_if, input int lat_d,
                             input logic [31:0] rif, input logic [31:0] rd,
                             input bit hold_if);
        int          order[$];
        int          cur;
        int          c;
        int          budget;
        int          lat[2];
        logic [31:0] rv[2];
        bit          done[2];
        bit          to;
        int          exp_cycles;
        cur = -1; c = 0; budget = 0;
        lat[0] = lat_if; lat[1] = lat_d;
        rv[0]  = rif;    rv[1]  = rd;
        done[0] = !w_if; done[1] = !w_d;
        if (w_if && w_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (m_last) begin order.push_back(0); order.push_back(1); end
            else        begin order.push_back(1); order.push_back(0); end
`else
            order.push_back(1); order.push_back(0);
            m_last = 1'b0;
`endif
        end else if (w_d) begin
            order.push_back(1); m_last = 1'b1;
        end else if (w_if) begin
            order.push_back(0); m_last = 1'b0;
        end
        if_req = w_if; if_addr = ia;
        d_req = w_d; d_we = dwe; d_addr = da; d_wdata = dwd;
        while (!(done[0] && done[1]) && budget < 100) begin
            @(negedge clk);
            budget++;
            if (cur < 0 && mem_req) begin
                chk("grant_expected", 64'(order.size() != 0), 64'd1);
                cur = (order.size() != 0) ? order.pop_front() : 0;
                c = 0;
            end
            if (cur >= 0) begin
                if (mem_req) begin
                    c++;
                    if (cur == 1) begin
                        chk("d_mem_addr", mem_addr, da);
                        chk("d_mem_we", mem_we, dwe);
                        chk("d_mem_wdata", mem_wdata, dwd);
                    end else begin
                        chk("if_mem_addr", mem_addr, ia);
                        chk("if_mem_we", mem_we, 0);
                    end
                    mem_ready = (c == lat[cur] + 1);
                    mem_rdata = mem_ready ? rv[cur] : $urandom;
                end else begin
                    to = lat[cur] > TO;
                    exp_cycles = to ? TO + 1 : lat[cur] + 1;
                    chk("req_cycles", c, exp_cycles);
                    chk("if_ack", if_ack, cur == 0);
                    chk("d_ack", d_ack, cur == 1);
                    chk("err", err, to);
                    if (!to) begin
                        if (cur == 0) m_if_rdata = rv[0];
                        else if (!dwe) m_d_rdata = rv[1];
                    end
                    chk("if_rdata", if_rdata, m_if_rdata);
                    chk("d_rdata", d_rdata, m_d_rdata);
                    if (cur == 0 && !hold_if) if_req = 1'b0;
                    if (cur == 1) d_req = 1'b0;
                    done[cur] = 1'b1;
                    cur = -1;
                    mem_ready = 1'b0;
                end
            end else begin
                chk("no_stray_ack", {if_ack, d_ack}, 0);
            end
        end
        if (budget >= 100) chk("trial_budget", 1, 0);
        // Quiet cycles: no further grant, acks gone (also covers a held fetch request).
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_idle_req", mem_req, 0);
            chk("post_idle_ack", {if_ack, d_ack}, 0);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench stalled");
    end

    initial begin
        reset = 1'b1;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks_err", {if_ack, d_ack, err}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, same-cycle ready.
        run_trial(1, 0, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
        // Store with three mem_req cycles; d_rdata must stay 0.
        run_trial(0, 1, 0, 32'h40, 32'h55, 1, 0, 2, 0, 32'hCAFE0000, 0);
        // Simultaneous requests.
        run_trial(1, 1, 32'h20, 32'h80, 32'h1234, 0, 1, 0, 32'h11112222, 32'h33334444, 0);
        // Boundary: ready exactly on the last allowed cycle, then a timeout.
        run_trial(1, 0, 32'h24, 0, 0, 0, TO, 0, 32'hA5A5A5A5, 0, 0);
        run_trial(1, 0, 32'h30, 0, 0, 0, 50, 0, 32'h0BADF00D, 0, 0);
        // Fetch request held through the ack cycle.
        run_trial(1, 0, 32'h14, 0, 0, 0, 0, 0, 32'h600DCAFE, 0, 1);

        // Reset in the middle of a data transaction.
        d_req = 1; d_we = 0; d_addr = 32'h99; d_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", mem_req, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_req", mem_req, 0);
        d_req = 0;
        m_if_rdata = '0; m_d_rdata = '0; m_last = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_ack", d_ack, 0);
        end
        chk("reset_if_rdata", if_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_no_ack", d_ack, 0);
        run_trial(0, 1, 0, 32'h44, 0, 0, 0, 1, 0, 32'h87654321, 0);

        // Randomized trials.
        for (int t = 0; t < 40; t++) begin
            bit wi, wd;
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            if (!wi && !wd) wi = 1'b1;
            run_trial(wi, wd, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
                      $urandom, $urandom, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
